// File: rtl/cpu_debug_unit_if.sv
// Debug-bus bundle between the JTAG TAP side (master) and the debug unit (slave).
interface cpu_debug_unit_if;
  logic        enable;
  logic        rd_wr;
  logic [31:0] address;
  logic [31:0] data_out;
  logic [31:0] data_in;

  modport master (
    output enable,
    output rd_wr,
    output address,
    output data_out,
    input  data_in
  );

  modport slave (
    input  enable,
    input  rd_wr,
    input  address,
    input  data_out,
    output data_in
  );
endinterface

// File: rtl/cpu_debug_unit.sv
// Debug controller: decodes debug-bus accesses into a small register file and
// drives the core halt line (halt / resume / single-step with counters).
module cpu_debug_unit #(
  parameter logic [31:0] DEBUG_ID     = 32'h0DB6_0001,
  parameter int unsigned NUM_SCRATCH  = 8,
  parameter bit          RESET_HALTED = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  cpu_debug_unit_if.slave        dbg,
  input  logic                   step,
  input  logic                   run,
  output logic                   halt
);
  localparam int unsigned DW      = 32;
  localparam int unsigned WORD_W  = 6;
  localparam int unsigned MAX_SCR = 8;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } run_state_t;

  run_state_t        state;
  logic              enable_q;
  logic              step_q;
  logic              run_q;
  logic [DW-1:0]     data_in_q;
  logic [DW-1:0]     step_cnt;
  logic [DW-1:0]     halt_cyc;
  logic [DW-1:0]     scratch [MAX_SCR];

  logic              access_c;
  logic              in_range_c;
  logic              wr_c;
  logic              rd_c;
  logic [WORD_W-1:0] word_c;
  logic              ctrl_wr_c;
  logic              halt_req_c;
  logic              resume_c;
  logic              step_req_c;
  logic              scr_hit_c;
  logic [DW-1:0]     rdata_c;
  logic              unused_c;

  assign dbg.data_in = data_in_q;
  assign unused_c    = ^dbg.address[1:0];

  // Access decode and one-shot run-control events from rising edges.
  always_comb begin
    access_c   = dbg.enable & ~enable_q;
    in_range_c = (dbg.address[31:8] == 24'd0);
    word_c     = dbg.address[7:2];
    wr_c       = access_c & dbg.rd_wr & in_range_c;
    rd_c       = access_c & ~dbg.rd_wr;
    ctrl_wr_c  = wr_c & (word_c == 6'd0);
    halt_req_c = ctrl_wr_c & dbg.data_out[0];
    resume_c   = (run & ~run_q) | (ctrl_wr_c & dbg.data_out[1]);
    step_req_c = (step & ~step_q) | (ctrl_wr_c & dbg.data_out[2]);
    scr_hit_c  = (word_c[5:3] == 3'd1) && (32'(word_c[2:0]) < NUM_SCRATCH);
  end

  // Read mux; out-of-range and unmapped words read as zero.
  always_comb begin
    rdata_c = '0;
    if (in_range_c) begin
      case (word_c)
        6'd1:    rdata_c = {30'd0, (state == ST_STEP), halt};
        6'd2:    rdata_c = step_cnt;
        6'd3:    rdata_c = halt_cyc;
        6'd4:    rdata_c = DEBUG_ID;
        default: if (scr_hit_c) rdata_c = scratch[word_c[2:0]];
      endcase
    end
  end

  // Run-control FSM, counters, register writes and registered read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RESET_HALTED ? ST_HALT : ST_RUN;
      halt      <= RESET_HALTED;
      enable_q  <= 1'b0;
      step_q    <= 1'b0;
      run_q     <= 1'b0;
      data_in_q <= '0;
      step_cnt  <= '0;
      halt_cyc  <= '0;
      for (int i = 0; i < int'(MAX_SCR); i++) scratch[i] <= '0;
    end else begin
      enable_q <= dbg.enable;
      step_q   <= step;
      run_q    <= run;

      if (rd_c) data_in_q <= rdata_c;

      if (halt && (halt_cyc != '1)) halt_cyc <= halt_cyc + DW'(1);

      // Priority: halt request > resume > step completion / step start.
      if (halt_req_c) begin
        state <= ST_HALT;
        halt  <= 1'b1;
      end else if (resume_c) begin
        state <= ST_RUN;
        halt  <= 1'b0;
      end else begin
        case (state)
          ST_STEP: begin
            state    <= ST_HALT;
            halt     <= 1'b1;
            step_cnt <= step_cnt + DW'(1);
          end
          ST_HALT: begin
            if (step_req_c) begin
              state <= ST_STEP;
              halt  <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      // Bus writes land last so a clear wins over a same-cycle increment.
      if (wr_c) begin
        case (word_c)
          6'd2:    step_cnt <= '0;
          6'd3:    halt_cyc <= '0;
          default: if (scr_hit_c) scratch[word_c[2:0]] <= dbg.data_out;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cpu_debug_unit.sv
// Bench for cpu_debug_unit: directed vector table, corner-case sequences and
// randomized traffic against a rule-level reference model.
module tb_cpu_debug_unit;
  localparam logic [31:0] ID = 32'h0DB6_0001;

  logic clk = 1'b0;
  logic reset;
  logic step;
  logic run;
  logic halt;

  cpu_debug_unit_if dbg();

  cpu_debug_unit dut (
    .clk   (clk),
    .reset (reset),
    .dbg   (dbg),
    .step  (step),
    .run   (run),
    .halt  (halt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: registers as named values, run mode as two flags.
  bit        m_halted;
  bit        m_stepping;
  bit [31:0] m_cnt;
  bit [31:0] m_cyc;
  bit [31:0] m_rd;
  bit [31:0] m_scr [8];
  bit        p_en, p_step, p_run;

  function automatic bit [31:0] m_read(input bit [31:0] a);
    bit [31:0] w;
    if (a >= 32'd256) return 32'd0;
    w = a & ~32'd3;
    if (w == 32'd4)  return {30'd0, m_stepping, m_halted};
    if (w == 32'd8)  return m_cnt;
    if (w == 32'd12) return m_cyc;
    if (w == 32'd16) return ID;
    if (w >= 32'd32 && w < 32'd64) return m_scr[(w - 32'd32) / 4];
    return 32'd0;
  endfunction

  task automatic model_edge(input bit r, e, w, input bit [31:0] a, d, input bit s, u);
    bit ev_en, ev_step, ev_run, is_ctrl, hreq, res, sreq, was_halted;
    bit [31:0] rv, wa;
    if (!r) begin
      m_halted = 1'b0; m_stepping = 1'b0; m_cnt = 0; m_cyc = 0; m_rd = 0;
      for (int i = 0; i < 8; i++) m_scr[i] = 0;
      p_en = 0; p_step = 0; p_run = 0;
      return;
    end
    ev_en   = e && !p_en;
    ev_step = s && !p_step;
    ev_run  = u && !p_run;
    p_en = e; p_step = s; p_run = u;
    rv = m_read(a);
    wa = a & ~32'd3;
    is_ctrl = ev_en && w && (a < 32'd256) && (wa == 0);
    hreq = is_ctrl && d[0];
    res  = ev_run || (is_ctrl && d[1]);
    sreq = ev_step || (is_ctrl && d[2]);
    was_halted = m_halted;
    if (was_halted && m_cyc != 32'hFFFF_FFFF) m_cyc++;
    if (hreq) begin
      m_halted = 1; m_stepping = 0;
    end else if (res) begin
      m_halted = 0; m_stepping = 0;
    end else if (m_stepping) begin
      m_halted = 1; m_stepping = 0; m_cnt++;
    end else if (sreq && m_halted) begin
      m_halted = 0; m_stepping = 1;
    end
    if (ev_en && w && a < 32'd256) begin
      if (wa == 32'd8) m_cnt = 0;
      else if (wa == 32'd12) m_cyc = 0;
      else if (wa >= 32'd32 && wa < 32'd64) m_scr[(wa - 32'd32) / 4] = d;
    end
    if (ev_en && !w) m_rd = rv;
  endtask

  // One clock: drive inputs, update the model at the edge, settle 1 time unit.
  task automatic tick(input bit r, e, w, input bit [31:0] a, d, input bit s, u);
    reset = r; dbg.enable = e; dbg.rd_wr = w; dbg.address = a; dbg.data_out = d;
    step = s; run = u;
    @(posedge clk);
    model_edge(r, e, w, a, d, s, u);
    #1;
  endtask

  typedef struct {
    bit        r, e, w;
    bit [31:0] a, d;
    bit        s, u;
    bit        h;
    bit [31:0] di;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, e, w, input bit [31:0] a, d,
                              input bit s, u, h, input bit [31:0] di);
    vec_t v;
    v.r = r; v.e = e; v.w = w; v.a = a; v.d = d; v.s = s; v.u = u; v.h = h; v.di = di;
    tbl.push_back(v);
  endfunction

  bit [31:0] addrs [14] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h20, 32'h27,
                            32'h3C, 32'h30, 32'h40, 32'h14, 32'h100, 32'hFFFF_FF10, 32'h0B};

  initial begin
    //   r  e  w  addr         data           s  u  halt data_in
    add(0, 0, 0, 32'h0,       32'h0,         0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,       32'h0,         0, 0, 0, 32'h0);
    add(1, 0, 0, 32'h0,       32'h0,         0, 0, 0, 32'h0);
    add(1, 1, 0, 32'h10,      32'h0,         0, 0, 0, ID);
    add(1, 0, 0, 32'h10,      32'h0,         0, 0, 0, ID);
    add(1, 1, 1, 32'h0,       32'h1,         0, 0, 1, ID);
    add(1, 0, 0, 32'h0,       32'h0,         0, 0, 1, ID);
    add(1, 0, 0, 32'h0,       32'h0,         0, 0, 1, ID);
    add(1, 0, 0, 32'h0,       32'h0,         0, 0, 1, ID);
    add(1, 1, 0, 32'h0C,      32'h0,         0, 0, 1, 32'd3);
    add(1, 0, 0, 32'h0C,      32'h0,         0, 0, 1, 32'd3);
    add(1, 1, 1, 32'h0C,      32'h1234,      0, 0, 1, 32'd3);
    add(1, 0, 0, 32'h0C,      32'h0,         0, 0, 1, 32'd3);
    add(1, 1, 0, 32'h0C,      32'h0,         0, 0, 1, 32'd1);
    add(1, 0, 0, 32'h0,       32'h0,         1, 0, 0, 32'd1);
    add(1, 0, 0, 32'h0,       32'h0,         1, 0, 1, 32'd1);
    add(1, 0, 0, 32'h0,       32'h0,         1, 0, 1, 32'd1);
    add(1, 0, 0, 32'h0,       32'h0,         0, 0, 1, 32'd1);
    add(1, 1, 0, 32'h08,      32'h0,         0, 0, 1, 32'd1);
    add(1, 0, 0, 32'h08,      32'h0,         1, 0, 0, 32'd1);
    add(1, 0, 0, 32'h08,      32'h0,         0, 0, 1, 32'd1);
    add(1, 1, 0, 32'h08,      32'h0,         0, 0, 1, 32'd2);
    add(1, 0, 0, 32'h0,       32'h0,         0, 1, 0, 32'd2);
    add(1, 0, 0, 32'h0,       32'h0,         0, 0, 0, 32'd2);
    add(1, 0, 0, 32'h0,       32'h0,         1, 0, 0, 32'd2);
    add(1, 1, 0, 32'h08,      32'h0,         0, 0, 0, 32'd2);
    add(1, 0, 0, 32'h0,       32'h0,         0, 0, 0, 32'd2);
    add(1, 1, 1, 32'h0,       32'h1,         0, 1, 1, 32'd2);
    add(1, 0, 0, 32'h0,       32'h0,         0, 0, 1, 32'd2);
    add(1, 1, 1, 32'h3C,      32'hDEAD_BEEF, 0, 0, 1, 32'd2);
    add(1, 0, 0, 32'h0,       32'h0,         0, 0, 1, 32'd2);
    add(1, 1, 0, 32'h3C,      32'h0,         0, 0, 1, 32'hDEAD_BEEF);
    add(1, 0, 0, 32'h0,       32'h0,         0, 0, 1, 32'hDEAD_BEEF);
    add(1, 1, 1, 32'h100,     32'hFFFF_FFFF, 0, 0, 1, 32'hDEAD_BEEF);
    add(1, 0, 0, 32'h0,       32'h0,         0, 0, 1, 32'hDEAD_BEEF);
    add(1, 1, 0, 32'h100,     32'h0,         0, 0, 1, 32'h0);
    add(1, 0, 0, 32'h0,       32'h0,         0, 0, 1, 32'h0);
    add(1, 1, 0, 32'h3C,      32'h0,         0, 0, 1, 32'hDEAD_BEEF);
    add(1, 0, 0, 32'h0,       32'h0,         0, 0, 1, 32'hDEAD_BEEF);
    add(1, 1, 0, 32'h04,      32'h0,         0, 0, 1, 32'h1);
    add(1, 0, 0, 32'h0,       32'h0,         1, 0, 0, 32'h1);
    add(1, 1, 0, 32'h04,      32'h0,         1, 0, 1, 32'h2);
    add(1, 0, 0, 32'h0,       32'h0,         0, 0, 1, 32'h2);
    add(1, 0, 0, 32'h0,       32'h0,         1, 0, 0, 32'h2);
    add(0, 0, 0, 32'h0,       32'h0,         1, 0, 0, 32'h0);
    add(1, 0, 0, 32'h0,       32'h0,         0, 0, 0, 32'h0);
    add(1, 1, 0, 32'h08,      32'h0,         0, 0, 0, 32'h0);
    add(1, 0, 0, 32'h0,       32'h0,         0, 0, 0, 32'h0);
    add(1, 1, 0, 32'h0C,      32'h0,         0, 0, 0, 32'h0);
    add(1, 0, 0, 32'h0,       32'h0,         0, 0, 0, 32'h0);

    reset = 1'b0; dbg.enable = 1'b0; dbg.rd_wr = 1'b0; dbg.address = '0;
    dbg.data_out = '0; step = 1'b0; run = 1'b0;

    foreach (tbl[i]) begin
      tick(tbl[i].r, tbl[i].e, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].u);
      check($sformatf("vec%0d halt", i), {31'd0, halt}, {31'd0, tbl[i].h});
      check($sformatf("vec%0d data_in", i), dbg.data_in, tbl[i].di);
    end

    // Resume via CTRL during a step: no re-halt, count unchanged.
    tick(1, 1, 1, 32'h0, 32'h1, 0, 0); check("seq halt_req", {31'd0, halt}, 32'd1);
    tick(1, 0, 0, 32'h0, 32'h0, 1, 0); check("seq step start", {31'd0, halt}, 32'd0);
    tick(1, 1, 1, 32'h0, 32'h2, 0, 0); check("seq resume in step", {31'd0, halt}, 32'd0);
    tick(1, 0, 0, 32'h0, 32'h0, 0, 0); check("seq stays running", {31'd0, halt}, 32'd0);
    tick(1, 1, 0, 32'h8, 32'h0, 0, 0); check("seq cnt after resume", dbg.data_in, 32'd0);
    tick(1, 0, 0, 32'h0, 32'h0, 0, 0);
    // Halt request during a step aborts it without counting.
    tick(1, 1, 1, 32'h0, 32'h1, 0, 0);
    tick(1, 0, 0, 32'h0, 32'h0, 1, 0); check("seq step2 start", {31'd0, halt}, 32'd0);
    tick(1, 1, 1, 32'h0, 32'h1, 0, 0); check("seq halt in step", {31'd0, halt}, 32'd1);
    tick(1, 0, 0, 32'h0, 32'h0, 0, 0); check("seq halt held", {31'd0, halt}, 32'd1);
    tick(1, 1, 0, 32'h8, 32'h0, 0, 0); check("seq cnt after abort", dbg.data_in, 32'd0);
    tick(1, 0, 0, 32'h0, 32'h0, 0, 0);
    // Run port during a step.
    tick(1, 0, 0, 32'h0, 32'h0, 1, 0); check("seq step3 start", {31'd0, halt}, 32'd0);
    tick(1, 0, 0, 32'h0, 32'h0, 0, 1); check("seq run in step", {31'd0, halt}, 32'd0);
    tick(1, 0, 0, 32'h0, 32'h0, 0, 0); check("seq running", {31'd0, halt}, 32'd0);
    tick(1, 1, 0, 32'h8, 32'h0, 0, 0); check("seq cnt after run", dbg.data_in, 32'd0);
    tick(1, 0, 0, 32'h0, 32'h0, 0, 0);
    // Step via CTRL.STEP counts once.
    tick(1, 1, 1, 32'h0, 32'h1, 0, 0);
    tick(1, 0, 0, 32'h0, 32'h0, 0, 0);
    tick(1, 1, 1, 32'h0, 32'h4, 0, 0); check("seq ctrl step start", {31'd0, halt}, 32'd0);
    tick(1, 0, 0, 32'h0, 32'h0, 0, 0); check("seq ctrl step end", {31'd0, halt}, 32'd1);
    tick(1, 1, 0, 32'h8, 32'h0, 0, 0); check("seq ctrl step cnt", dbg.data_in, 32'd1);
    tick(1, 0, 0, 32'h0, 32'h0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r, e, w, s, u;
      bit [31:0] a, d;
      r = ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 1) == 1);
      w = ($urandom_range(0, 2) == 0);
      a = addrs[$urandom_range(0, 13)];
      d = $urandom;
      s = ($urandom_range(0, 5) == 0);
      u = ($urandom_range(0, 11) == 0);
      tick(r, e, w, a, d, s, u);
      check($sformatf("rnd%0d halt", i), {31'd0, halt}, {31'd0, m_halted});
      check($sformatf("rnd%0d data_in", i), dbg.data_in, m_rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
